// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings and helpers for the sequential multiplier
package mul_pkg;

    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        CALC,
        NEG_LO,
        NEG_HI,
        DONE
    } state_e;

    function automatic logic a_signed(input op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic b_signed(input op_e op);
        return op == MULH;
    endfunction

endpackage

// File: rtl/cla_fulladder32.sv
// cla_fulladder32: 32-bit adder built from eight 4-bit carry-lookahead groups
module cla_fulladder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);
    logic [31:0] p, g;
    logic [32:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;
    assign sum_o = p ^ c[31:0];
    assign carry_o = c[32];

    // lookahead carries inside each group, group carry-out feeds the next group
    always_comb begin
        c = '0;
        c[0] = carry_i;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k+:2] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1+:2] & g[4*k])
                     | (&p[4*k+:3] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2+:2] & g[4*k+1])
                     | (&p[4*k+1+:3] & g[4*k]) | (&p[4*k+:4] & c[4*k]);
        end
    end

endmodule

// File: rtl/mul_seq32.sv
// mul_seq32: sequential 32x32 shift-add multiplier (MUL/MULH/MULHSU/MULHU) on one shared adder
module mul_seq32
    import mul_pkg::*;
#(
    parameter int ITER = MUL_ITER
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);
    state_e      state_q, state_d;
    op_e         op_q;
    logic [31:0] a_q, b_q, hi_q, mq_q;
    logic [31:0] add_a, add_b, sum;
    logic        add_c, cout, neg_q, cl_q, a_neg, b_neg;
    logic [4:0]  cnt_q;

    assign a_neg = a_signed(op_q) & a_q[31];
    assign b_neg = b_signed(op_q) & b_q[31];

    cla_fulladder32 u_add (
        .a_i     (add_a),
        .b_i     (add_b),
        .carry_i (add_c),
        .sum_o   (sum),
        .carry_o (cout)
    );

    // steer the shared adder: negations use ~x + carry, CALC accumulates the partial product
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_c = 1'b0;
        case (state_q)
            ABS_A:   begin add_a = ~a_q;  add_c = 1'b1; end
            ABS_B:   begin add_a = ~b_q;  add_c = 1'b1; end
            CALC:    begin add_a = hi_q;  add_b = mq_q[0] ? a_q : '0; end
            NEG_LO:  begin add_a = ~mq_q; add_c = 1'b1; end
            NEG_HI:  begin add_a = ~hi_q; add_c = cl_q; end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next-state logic: fixed walk through the sequence, CALC loops ITER times
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = valid_i ? ABS_A : IDLE;
            ABS_A:   state_d = ABS_B;
            ABS_B:   state_d = CALC;
            CALC:    state_d = (cnt_q == 5'(ITER - 1)) ? NEG_LO : CALC;
            NEG_LO:  state_d = NEG_HI;
            NEG_HI:  state_d = DONE;
            DONE:    state_d = ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // outputs: result is only visible while valid_o is high
    always_comb begin
        ready_o  = state_q == IDLE;
        busy_o   = state_q != IDLE;
        valid_o  = state_q == DONE;
        result_o = valid_o ? ((op_q == MUL) ? mq_q : hi_q) : '0;
    end

    // datapath: capture, take magnitudes, shift-add, then two's-complement the 64-bit product
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= MUL;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            mq_q  <= '0;
            neg_q <= 1'b0;
            cl_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    op_q <= op_e'(op_i);
                    a_q  <= a_i;
                    b_q  <= b_i;
                end
                ABS_A: begin
                    neg_q <= a_neg ^ b_neg;
                    if (a_neg) a_q <= sum;
                end
                ABS_B: begin
                    b_q  <= b_neg ? sum : b_q;
                    mq_q <= b_neg ? sum : b_q;
                    hi_q <= '0;
                end
                CALC: begin
                    hi_q  <= {cout, sum[31:1]};
                    mq_q  <= {sum[0], mq_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                end
                NEG_LO: if (neg_q) begin
                    mq_q <= sum;
                    cl_q <= cout;
                end
                NEG_HI: if (neg_q) hi_q <= sum;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_seq32.md
MUL_SEQ32 -- requirements
Module: mul_seq32

Interface
REQ-001 SHALL have parameter ITER, default 32, giving the number of shift-add iterations; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1 bit: request valid.
REQ-005 SHALL have port ready_o, output, 1 bit: unit accepts a request.
REQ-006 SHALL have port op_i, input, 2 bits: operation select; 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port a_i, input, 32 bits: multiplicand (rs1).
REQ-008 SHALL have port b_i, input, 32 bits: multiplier (rs2).
REQ-009 SHALL have port valid_o, output, 1 bit: result valid.
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result_o, output, 32 bits: low product word for MUL, high product word otherwise.
REQ-012 SHALL have port busy_o, output, 1 bit: FSM not in IDLE.

Function
REQ-013 SHALL perform every addition, including operand and result negation, through one shared 32-bit carry-lookahead adder; no other adders are permitted.
REQ-014 SHALL accept a request on valid_i & ready_o; ready_o is high only in IDLE; op_i, a_i and b_i are registered at acceptance.
REQ-015 SHALL use FSM states IDLE -> ABS_A -> ABS_B -> CALC -> NEG_LO -> NEG_HI -> DONE -> IDLE.
REQ-016 SHALL use the following operand signedness: a is signed for MULH and MULHSU; b is signed for MULH only; MUL treats both operands as unsigned.
REQ-017 SHALL, in ABS_A, replace a with ~a + 1 (adder with b=0, carry_i=1) if a is signed and a[31]=1; otherwise hold a; ABS_B does the same for b.
REQ-018 SHALL hold neg_flag = (a signed & a[31]) ^ (b signed & b[31]), computed from the registered, un-negated operands.
REQ-019 SHALL run CALC for exactly ITER cycles, tracked by a 5-bit counter that wraps from 31 to 0 on exit.
REQ-020 SHALL, in each CALC cycle, compute {c,s} = hi + (mq[0] ? a : 0) and then update {hi,mq} <= {c,s,mq} >> 1.
REQ-021 SHALL, in NEG_LO, set lo <= ~lo + 1 and latch the adder carry_o if neg_flag; otherwise hold.
REQ-022 SHALL, in NEG_HI, set hi <= ~hi + latched carry if neg_flag; otherwise hold.
REQ-023 SHALL use fixed latency: acceptance at cycle 0 gives valid_o high at cycle 37 regardless of operands.
REQ-024 SHALL, in DONE, hold valid_o and result_o stable until ready_i; on valid_o & ready_i, go to IDLE; ready_o returns high the following cycle.
REQ-025 SHALL ignore valid_i while busy_o is high; no queuing.
REQ-026 SHALL hold result_o at 0 when valid_o is low.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously force state to IDLE, the counter, hi, mq, a, b, neg_flag and the carry latch to 0, valid_o to 0, ready_o to 1, busy_o to 0 and result_o to 0.
REQ-028 SHALL discard any in-flight operation when reset is asserted in any state; no result is produced for it.
REQ-029 SHALL accept a new request in the first cycle after rst_ni deasserts.

Structure
REQ-030 SHALL define in shared package mul_pkg: the op encoding enum (MUL, MULH, MULHSU, MULHU), the FSM state enum, and the constant MUL_ITER = 32.
REQ-031 SHALL instantiate exactly one existing cla_fulladder32 sub-module, driven by a per-state operand/carry multiplexer.
REQ-032 SHALL fit the FSM, datapath registers and multiplexer in 120-400 lines of RTL.

Verification
REQ-033 SHALL test MUL 7 x 6, ready_i high -> valid_o rises exactly 37 cycles after acceptance, result_o = 0x0000002A.
REQ-034 SHALL test MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-035 SHALL test MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0x00000005 -> 0xFFFFFFFF.
REQ-036 SHALL test MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000001.
REQ-037 SHALL test backpressure: ready_i held low for 3 cycles in DONE -> valid_o and result_o stable for all 3 cycles; valid_i pulses while busy are ignored.
REQ-038 SHALL test reset mid-operation: rst_ni low at CALC iteration 10 -> all outputs immediately at reset values; a new request afterwards gives a correct result at 37-cycle latency.
